// File: rtl/lsu_pkg.sv
// Shared definitions for the sequential load/store unit: opcodes, FSM states,
// operation kinds and immediate-offset helpers.
package lsu_pkg;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [9:0]  OPC_LDP  = 10'b1010100011;
    localparam logic [9:0]  OPC_STP  = 10'b1010100010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } lsu_state_t;

    typedef enum logic [2:0] {
        OP_LDUR,
        OP_STUR,
        OP_LDP,
        OP_STP,
        OP_ILL
    } op_kind_t;

    function automatic logic signed [63:0] unscaled_offset(input logic [8:0] imm9);
        return 64'(signed'(imm9));
    endfunction

    // Pair offsets count whole registers, so the signed imm7 is scaled by the register size.
    function automatic logic signed [63:0] scaled_offset(input logic [6:0] imm7, input int shift);
        logic signed [63:0] ext;
        ext = 64'(signed'(imm7));
        return ext <<< shift;
    endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of the upper instruction bits into an operation kind
// and the one or two effective addresses it touches.
module lsu_decode
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic [31:12]      inst_hi,
    input  logic [ADDR_W-1:0] base,
    output op_kind_t          kind,
    output logic [ADDR_W-1:0] addr0,
    output logic [ADDR_W-1:0] addr1
);

    localparam int BYTES = DATA_W / 8;
    localparam int SHIFT = $clog2(BYTES);

    always_comb begin
        kind = OP_ILL;
        if (inst_hi[31:21] == OPC_LDUR)      kind = OP_LDUR;
        else if (inst_hi[31:21] == OPC_STUR) kind = OP_STUR;
        else if (inst_hi[31:22] == OPC_LDP)  kind = OP_LDP;
        else if (inst_hi[31:22] == OPC_STP)  kind = OP_STP;

        if (kind == OP_LDP || kind == OP_STP)
            addr0 = base + ADDR_W'(scaled_offset(inst_hi[21:15], SHIFT));
        else
            addr0 = base + ADDR_W'(unscaled_offset(inst_hi[20:12]));
        addr1 = addr0 + ADDR_W'(BYTES);
    end

endmodule

// File: rtl/fu_lsu_seq.sv
// Multi-cycle load/store functional unit (LDUR/STUR/LDP/STP) with valid/ready
// memory requests, a read-response strobe and a held result until writeback.
module fu_lsu_seq
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int TAG_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    input  logic [TAG_W-1:0]  inst_tag,
    input  logic [DATA_W-1:0] op0,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic              fu_ready,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [1:0]        out_data_valid,
    output logic              out_fault
);

    lsu_state_t        state, state_nxt;
    logic [31:12]      inst_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] op0_q, op1_q, op2_q;
    logic [DATA_W-1:0] data0_q, data1_q;

    op_kind_t          kind;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [31:12]      dec_inst;
    logic [DATA_W-1:0] dec_base;
    logic              accept;
    logic              is_store;

    // In IDLE the incoming instruction is decoded so an illegal opcode can skip memory.
    assign dec_inst = (state == S_IDLE) ? inst[31:12] : inst_q;
    assign dec_base = (state == S_IDLE) ? op0 : op0_q;

    lsu_decode #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .inst_hi (dec_inst),
        .base    (ADDR_W'(dec_base)),
        .kind    (kind),
        .addr0   (addr0),
        .addr1   (addr1)
    );

    assign accept   = (state == S_IDLE) && inst_valid && !flush;
    assign is_store = (kind == OP_STUR) || (kind == OP_STP);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (inst_valid) state_nxt = (kind == OP_ILL) ? S_RESP : S_REQ0;
            S_REQ0: begin
                if (mem_req_ready) begin
                    case (kind)
                        OP_LDUR, OP_LDP: state_nxt = S_WAIT0;
                        OP_STP:          state_nxt = S_REQ1;
                        default:         state_nxt = S_RESP;
                    endcase
                end
            end
            S_WAIT0: if (mem_rvalid) state_nxt = (kind == OP_LDP) ? S_REQ1 : S_RESP;
            S_REQ1:  if (mem_req_ready) state_nxt = (kind == OP_LDP) ? S_WAIT1 : S_RESP;
            S_WAIT1: if (mem_rvalid) state_nxt = S_RESP;
            S_RESP:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_comb begin
        fu_ready       = (state == S_IDLE);
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        out_valid      = 1'b0;
        out_data_valid = 2'b00;
        out_fault      = 1'b0;
        if (state == S_REQ0 || state == S_REQ1) begin
            mem_req_valid = 1'b1;
            mem_req_we    = is_store;
            mem_req_addr  = (state == S_REQ1) ? addr1 : addr0;
            if (is_store) mem_req_wdata = (state == S_REQ1) ? op2_q : op1_q;
        end
        if (state == S_RESP) begin
            out_valid = 1'b1;
            out_fault = (kind == OP_ILL);
            if (kind == OP_LDUR)     out_data_valid = 2'b01;
            else if (kind == OP_LDP) out_data_valid = 2'b11;
        end
    end

    assign out_tag   = tag_q;
    assign out_data0 = data0_q;
    assign out_data1 = data1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            inst_q  <= '0;
            tag_q   <= '0;
            op0_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                inst_q <= inst[31:12];
                tag_q  <= inst_tag;
                op0_q  <= op0;
                op1_q  <= op1;
                op2_q  <= op2;
            end
            // A response after a flush finds the unit out of WAIT and is dropped.
            if (!flush && state == S_WAIT0 && mem_rvalid) data0_q <= mem_rdata;
            if (!flush && state == S_WAIT1 && mem_rvalid) data1_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fu_lsu_seq.sv
// Self-checking bench for fu_lsu_seq: directed scenarios plus randomized
// instructions compared against an architectural-level reference model.
module tb_fu_lsu_seq;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int TAG_W  = 6;

    logic              clk = 1'b0;
    logic              rst, flush, inst_valid;
    logic [31:0]       inst;
    logic [TAG_W-1:0]  inst_tag;
    logic [DATA_W-1:0] op0, op1, op2;
    logic              fu_ready, mem_req_valid, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_req_ready, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid, out_ready;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data0, out_data1;
    logic [1:0]        out_data_valid;
    logic              out_fault;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] mem [logic [63:0]];

    fu_lsu_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .inst_valid(inst_valid), .inst(inst),
        .inst_tag(inst_tag), .op0(op0), .op1(op1), .op2(op2), .fu_ready(fu_ready),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_data0(out_data0), .out_data1(out_data1), .out_data_valid(out_data_valid),
        .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 64'h9E3779B97F4A7C15) ^ 64'h5555;
    endfunction

    function automatic logic [31:0] enc_ldst(input bit ld, input logic [8:0] imm9,
                                              input logic [4:0] rn, input logic [4:0] rt);
        logic [10:0] opc;
        opc = ld ? 11'h7C2 : 11'h7C0;
        return {opc, imm9, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] enc_pair(input bit ld, input logic [6:0] imm7,
                                              input logic [4:0] rt2, input logic [4:0] rn,
                                              input logic [4:0] rt);
        logic [9:0] opc;
        opc = ld ? 10'h2A3 : 10'h2A2;
        return {opc, imm7, rt2, rn, rt};
    endfunction

    // Kinds: 0 LDUR, 1 STUR, 2 LDP, 3 STP, 4 illegal.
    task automatic model(input logic [31:0] i, input logic [63:0] base, output int kind,
                         output logic [63:0] a0, output logic [63:0] a1);
        longint off;
        logic signed [8:0] s9;
        logic signed [6:0] s7;
        s9 = i[20:12];
        s7 = i[21:15];
        if (i[31:21] == 11'h7C2)      kind = 0;
        else if (i[31:21] == 11'h7C0) kind = 1;
        else if (i[31:22] == 10'h2A3) kind = 2;
        else if (i[31:22] == 10'h2A2) kind = 3;
        else                          kind = 4;
        if (kind == 2 || kind == 3) off = longint'(s7) * 8;
        else                        off = longint'(s9);
        a0 = base + 64'(off);
        a1 = a0 + 64'd8;
    endtask

    task automatic run_inst(input logic [31:0] i, input logic [TAG_W-1:0] tag,
                            input logic [63:0] b, input logic [63:0] d1, input logic [63:0] d2,
                            input int req_stall, input int rdelay, input int out_stall);
        int kind, nreq, exp_lat, cyc, beat, stall, ostall, rcnt, w;
        logic [63:0] a0, a1, exp_a, raddr, exp_wd;
        logic [1:0] exp_dv;
        bit exp_we, pend, out_seen, done, busy_bad;
        model(i, b, kind, a0, a1);
        nreq    = (kind == 4) ? 0 : (kind <= 1) ? 1 : 2;
        exp_we  = (kind == 1 || kind == 3);
        exp_dv  = (kind == 0) ? 2'b01 : (kind == 2) ? 2'b11 : 2'b00;
        case (kind)
            0:       exp_lat = 3 + req_stall + rdelay;
            1:       exp_lat = 2 + req_stall;
            2:       exp_lat = 5 + req_stall + 2 * rdelay;
            3:       exp_lat = 3 + req_stall;
            default: exp_lat = 1;
        endcase

        w = 0;
        while (!fu_ready && w < 50) begin tick(); w++; end
        check("fu_ready_before_issue", 64'(fu_ready), 64'd1);
        inst_valid = 1'b1; inst = i; inst_tag = tag; op0 = b; op1 = d1; op2 = d2;
        tick();
        inst_valid = 1'b0; inst = $urandom; op0 = {$urandom, $urandom};
        op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};

        cyc = 1; beat = 0; stall = req_stall; ostall = out_stall; rcnt = 0; raddr = '0;
        pend = 0; out_seen = 0; done = 0; busy_bad = 0;
        while (!done && cyc < 300) begin
            mem_rvalid = 1'b0; mem_req_ready = 1'b0; out_ready = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (fu_ready) busy_bad = 1;
            if (pend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = mem_rd(raddr); pend = 0;
                end else rcnt--;
            end
            if (mem_req_valid) begin
                if (beat >= nreq) check("unexpected_req", 64'(mem_req_valid), 64'd0);
                exp_a  = (beat == 0) ? a0 : a1;
                exp_wd = (beat == 0) ? d1 : d2;
                check("req_addr", mem_req_addr, exp_a);
                check("req_we", 64'(mem_req_we), 64'(exp_we));
                if (exp_we) check("req_wdata", mem_req_wdata, exp_wd);
                if (beat == 0 && stall > 0) stall--;
                else begin
                    mem_req_ready = 1'b1;
                    if (mem_req_we) mem[mem_req_addr] = mem_req_wdata;
                    else begin pend = 1; rcnt = rdelay; raddr = mem_req_addr; end
                    beat++;
                end
            end
            if (out_valid) begin
                if (!out_seen) begin
                    out_seen = 1;
                    check("out_latency", 64'(cyc), 64'(exp_lat));
                end
                check("out_tag", 64'(out_tag), 64'(tag));
                check("out_data_valid", 64'(out_data_valid), 64'(exp_dv));
                check("out_fault", 64'(out_fault), 64'(kind == 4));
                if (kind == 0 || kind == 2) check("out_data0", out_data0, mem_rd(a0));
                if (kind == 2) check("out_data1", out_data1, mem_rd(a1));
                if (ostall > 0) ostall--;
                else begin out_ready = 1'b1; done = 1; end
            end
            tick();
            cyc++;
        end
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
        check("completed", 64'(done), 64'd1);
        check("req_count", 64'(beat), 64'(nreq));
        check("busy_while_inflight", 64'(busy_bad), 64'd0);
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("fu_ready_after", 64'(fu_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fu_ready"}, 64'(fu_ready), 64'd1);
        check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_req_we"}, 64'(mem_req_we), 64'd0);
        check({tag, "_req_addr"}, mem_req_addr, 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data_valid"}, 64'(out_data_valid), 64'd0);
        check({tag, "_fault"}, 64'(out_fault), 64'd0);
        check({tag, "_tag"}, 64'(out_tag), 64'd0);
        check({tag, "_data0"}, out_data0, 64'd0);
        check({tag, "_data1"}, out_data1, 64'd0);
    endtask

    initial begin
        logic [31:0] ri;
        rst = 1'b1; flush = 1'b0; inst_valid = 1'b0; inst = '0; inst_tag = '0;
        op0 = '0; op1 = '0; op2 = '0; mem_req_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // LDUR with negative byte offset, zero-wait memory
        mem[64'h0FF8] = 64'hDEAD;
        run_inst(enc_ldst(1'b1, 9'h1F8, 5'd1, 5'd2), 6'd5, 64'h1000, 0, 0, 0, 0, 0);
        check("ldur_data", out_data0, 64'hDEAD);

        // STP with a stalled first request
        run_inst(enc_pair(1'b0, 7'd2, 5'd3, 5'd4, 5'd5), 6'd9, 64'h2000, 64'hA, 64'hB, 3, 0, 0);
        check("stp_mem0", mem_rd(64'h2010), 64'hA);
        check("stp_mem1", mem_rd(64'h2018), 64'hB);

        // LDP with slow responses and writeback backpressure
        run_inst(enc_pair(1'b1, 7'h7F, 5'd7, 5'd8, 5'd7), 6'd17, 64'h3000, 0, 0, 0, 5, 4);

        // Illegal opcode
        run_inst(32'h0000_0000, 6'd33, 64'h1234, 0, 0, 0, 0, 0);

        // Flush in WAIT0, then a late response
        inst_valid = 1'b1; inst = enc_ldst(1'b1, 9'd16, 5'd1, 5'd1); inst_tag = 6'd40;
        op0 = 64'h5000;
        tick();
        inst_valid = 1'b0;
        check("flush_req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("flush_wait0_no_req", 64'(mem_req_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fu_ready", 64'(fu_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_req_valid_after", 64'(mem_req_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD0BAD0;
        tick();
        mem_rvalid = 1'b0;
        check("late_rvalid_out_valid", 64'(out_valid), 64'd0);
        check("late_rvalid_data0", 64'(out_data0 == 64'hBAD0BAD0), 64'd0);
        tick();
        check("late_rvalid_idle", 64'(out_valid), 64'd0);
        run_inst(enc_ldst(1'b1, 9'd24, 5'd2, 5'd3), 6'd41, 64'h5000, 0, 0, 1, 2, 1);

        // Reset while the STP second request is pending
        inst_valid = 1'b1; inst = enc_pair(1'b0, 7'd1, 5'd2, 5'd3, 5'd4); inst_tag = 6'd50;
        op0 = 64'h4000; op1 = 64'h11; op2 = 64'h22;
        tick();
        inst_valid = 1'b0;
        mem_req_ready = 1'b1;
        if (mem_req_valid) mem[mem_req_addr] = mem_req_wdata;
        tick();
        mem_req_ready = 1'b0;
        check("rst_req1_valid", 64'(mem_req_valid), 64'd1);
        check("rst_req1_addr", mem_req_addr, 64'h4010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midop_reset");
        mem_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_second_write", 64'(mem_req_valid), 64'd0);
        end
        mem_req_ready = 1'b0;

        // Randomized mix against the reference model
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0: ri = enc_ldst(1'b1, 9'($urandom), 5'($urandom), 5'($urandom));
                1: ri = enc_ldst(1'b0, 9'($urandom), 5'($urandom), 5'($urandom));
                2: ri = enc_pair(1'b1, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
                3: ri = enc_pair(1'b0, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
                default: ri = $urandom;
            endcase
            run_inst(ri, 6'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fu_lsu_seq.md
Name: fu_lsu_seq

Overview:
- Parametrised successor functional unit for load/store: executes LDUR, STUR, LDP and STP as a multi-cycle FSM.
- Talks to memory through a valid/ready request port plus a separate read-response strobe; holds results until the writeback stage accepts them.
- Sits beside the other functional units behind the issue stage; one instruction in flight at a time.
- Adds, beyond the single-cycle LSU: sign-extended and scaled immediates, memory backpressure, result backpressure, flush, and an illegal-opcode fault flag.

Parameters:
- DATA_W, 64, width of operands, memory data and results.
- ADDR_W, 64, memory address width.
- TAG_W, 6, width of the destination/ROB tag carried with the instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  abort the in-flight instruction and return to IDLE.
- inst_valid  in  1  issue presents an instruction.
- inst  in  32  AArch64 encoding.
- inst_tag  in  TAG_W  tag returned with the result.
- op0  in  DATA_W  base address register value.
- op1  in  DATA_W  store data (Rt).
- op2  in  DATA_W  second store data (Rt2, STP only).
- fu_ready  out  1  unit can accept an instruction this cycle.
- mem_req_valid  out  1  memory request valid.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_wdata  out  DATA_W  write data.
- mem_req_ready  in  1  memory accepts the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- out_tag  out  TAG_W  tag of the result.
- out_data0  out  DATA_W  first load result.
- out_data1  out  DATA_W  second load result (LDP).
- out_data_valid  out  2  per-result writeback enables.
- out_fault  out  1  illegal or unsupported opcode.

Behaviour:
- Reset, synchronous active-high: state=IDLE; fu_ready=1; mem_req_valid=0; out_valid=0; out_data_valid=0; out_fault=0; all data, address and tag registers=0.
- Accept: in IDLE, inst_valid=1 with fu_ready=1 latches inst, tag, op0..op2 and drops fu_ready the next cycle.
  - fu_ready=1 only in IDLE.
- Decode:
  - LDUR is inst[31:21]=11111000010; STUR is 11111000000.
  - LDP is inst[31:22]=1010100011; STP is 1010100010.
  - Anything else is illegal.
- Address arithmetic (all modulo 2^ADDR_W, no overflow detection):
  - LDUR/STUR: addr0 = op0 + sext(inst[20:12]), a byte offset.
  - LDP/STP: addr0 = op0 + (sext(inst[21:15]) << log2(DATA_W/8)); addr1 = addr0 + DATA_W/8.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on accept go to REQ0; an illegal opcode goes directly to RESP with out_fault=1 and no memory request.
- REQ0: drive mem_req_valid=1 with addr0; mem_req_we=1 and wdata=op1 for stores.
  - Hold all request fields stable until mem_req_ready=1.
  - On handshake: a load goes to WAIT0; STUR goes to RESP; STP goes to REQ1.
- WAIT0: mem_req_valid=0. On mem_rvalid, capture mem_rdata into out_data0; LDUR then goes to RESP, LDP to REQ1.
- REQ1: drive addr1; wdata=op2 for STP.
  - On handshake: STP goes to RESP; LDP goes to WAIT1.
- WAIT1: on mem_rvalid, capture into out_data1 and go to RESP.
- RESP: out_valid=1, with out_data_valid set as follows:
  - LDUR: 01.
  - LDP: 11.
  - STUR, STP or fault: 00.
  - On out_ready=1 clear out_valid and out_fault, go to IDLE, and set fu_ready=1 the next cycle. No back-to-back accept in the same cycle as the RESP handshake.
- Latency:
  - LDUR with zero-wait memory and out_ready=1: accept at cycle 0, REQ0 at cycle 1, rvalid at cycle 2, out_valid at cycle 3.
  - STUR: out_valid at cycle 2.
- mem_rvalid outside a WAIT state is ignored.
- LDP with Rt==Rt2 is not checked; both results are returned.
- flush: has priority over everything except rst. Any state goes to IDLE next cycle with mem_req_valid=0, out_valid=0 and fu_ready=1.
  - A read response arriving after a flush is ignored.
  - A store already handshaken is not undone.
- rst mid-operation: same as flush, plus all registers are cleared.

Decomposition:
- Package lsu_pkg holds:
  - the opcode localparams (LDUR/STUR/LDP/STP);
  - the state enum lsu_state_t;
  - the op-kind enum {OP_LDUR, OP_STUR, OP_LDP, OP_STP, OP_ILL};
  - the function that computes scaled offsets.
- One sub-module, lsu_decode: purely combinational inst→{op kind, addr0, addr1}. The FSM lives in fu_lsu_seq.

Test Plan:
- LDUR, op0=0x1000, imm9=-8 (0x1F8), zero-wait memory returning 0xDEAD → request addr 0x0FF8 with we=0; out_data0=0xDEAD, out_data_valid=01, out_valid at cycle 3.
- STP, op0=0x2000, imm7=2, op1=0xA, op2=0xB, mem_req_ready low for 3 cycles on the first request → request fields held stable while stalled; writes (0x2010,0xA) then (0x2018,0xB); out_data_valid=00.
- LDP, rvalid delayed 5 cycles per beat, out_ready low 4 cycles → data0 from addr0, data1 from addr0+8; out_valid held with stable data until out_ready; fu_ready stays 0 throughout.
- Illegal inst 0x00000000 → no mem_req_valid ever; out_valid with out_fault=1 one cycle after accept.
- flush asserted in WAIT0 of LDUR, then a late mem_rvalid → IDLE next cycle, fu_ready=1, no out_valid, late data ignored; the next LDUR completes normally.
- rst asserted in REQ1 of STP → all outputs at reset values next cycle and no second write issued.
